// File: rtl/display_arbiter_pkg.sv
// Shared definitions for the display arbiter slice: FSM encoding,
// default data width and a constant-evaluable clog2.
package display_arbiter_pkg;

  localparam int DEF_DATA_W = 16;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SHOW = 1'b1;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((32'sd1 << r) < value) begin
      r = r + 32'sd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_arbiter_if.sv
// Bundle between the display producers (master) and the arbiter (slave).
interface display_arbiter_if
  import display_arbiter_pkg::*;
#(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = DEF_DATA_W
);

  localparam int ID_W = clog2(NUM_SRC);

  logic [NUM_SRC-1:0]        Req;
  logic [NUM_SRC*DATA_W-1:0] Data;
  logic                      Hold;
  logic [NUM_SRC-1:0]        Ack;
  logic [DATA_W-1:0]         Result;
  logic [ID_W-1:0]           Src_ID;
  logic                      Disp_Valid;

  modport master (
    output Req, Data, Hold,
    input  Ack, Result, Src_ID, Disp_Valid
  );

  modport slave (
    input  Req, Data, Hold,
    output Ack, Result, Src_ID, Disp_Valid
  );

endinterface

// File: rtl/display_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester strictly above `last`,
// otherwise the lowest-index requester (the wrap-around case).
module rr_pick #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [ID_W-1:0]    last,
  output logic [ID_W-1:0]    g,
  output logic               any_req
);

  logic            hi_found_s;
  logic            lo_found_s;
  logic [ID_W-1:0] hi_g_s;
  logic [ID_W-1:0] lo_g_s;

  // Scan once, tracking the lowest requester above last and the lowest overall.
  always_comb begin
    hi_found_s = 1'b0;
    lo_found_s = 1'b0;
    hi_g_s     = '0;
    lo_g_s     = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (req[i] && !lo_found_s) begin
        lo_found_s = 1'b1;
        lo_g_s     = ID_W'(i);
      end else begin
        lo_found_s = lo_found_s;
      end
      if (req[i] && !hi_found_s && (ID_W'(i) > last)) begin
        hi_found_s = 1'b1;
        hi_g_s     = ID_W'(i);
      end else begin
        hi_found_s = hi_found_s;
      end
    end
  end

  // Select the wrapped candidate only when nothing sits above last.
  always_comb begin
    if (hi_found_s) begin
      g = hi_g_s;
    end else begin
      g = lo_g_s;
    end
    any_req = |req;
  end

endmodule

// File: rtl/display_arbiter.sv
// Round-robin owner of the 7-segment display path: grants one source at a
// time and keeps its value on Result for at least HOLD_CYCLES cycles.
module display_arbiter
  import display_arbiter_pkg::*;
#(
  parameter int NUM_SRC     = 4,
  parameter int DATA_W      = DEF_DATA_W,
  parameter int HOLD_CYCLES = 1024
) (
  input logic              CLK,
  input logic              Reset,
  display_arbiter_if.slave bus
);

  localparam int                  ID_W       = clog2(NUM_SRC);
  localparam int                  CNT_W      = clog2(HOLD_CYCLES + 1);
  localparam logic [CNT_W-1:0]    CNT_RELOAD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [ID_W-1:0]     LAST_RST   = ID_W'(NUM_SRC - 1);
  localparam logic [NUM_SRC-1:0]  ONE_HOT0   = {{(NUM_SRC-1){1'b0}}, 1'b1};

  logic [0:0]         state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [ID_W-1:0]    last_r;
  logic [DATA_W-1:0]  result_r;
  logic [ID_W-1:0]    src_r;
  logic [NUM_SRC-1:0] ack_r;
  logic               valid_r;

  logic [ID_W-1:0]    g_s;
  logic               any_s;
  logic               grant_s;
  logic               dec_s;
  logic               to_idle_s;
  logic [DATA_W-1:0]  data_arr_s [NUM_SRC];

  rr_pick #(
    .NUM_SRC (NUM_SRC),
    .ID_W    (ID_W)
  ) u_pick (
    .req     (bus.Req),
    .last    (last_r),
    .g       (g_s),
    .any_req (any_s)
  );

  // Split the flat Data bus into per-source slices.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      data_arr_s[i] = bus.Data[i*DATA_W +: DATA_W];
    end
  end

  // Next-action decode; Hold freezes the dwell and blocks grants in every state.
  always_comb begin
    grant_s   = 1'b0;
    dec_s     = 1'b0;
    to_idle_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!bus.Hold && any_s) begin
          grant_s = 1'b1;
        end else begin
          grant_s = 1'b0;
        end
      end
      ST_SHOW: begin
        if (bus.Hold) begin
          grant_s = 1'b0;
        end else if (cnt_r != '0) begin
          dec_s = 1'b1;
        end else if (any_s) begin
          grant_s = 1'b1;
        end else begin
          to_idle_s = 1'b1;
        end
      end
      default: begin
        to_idle_s = 1'b1;
      end
    endcase
  end

  // FSM, dwell counter and registered outputs; Ack is a single-cycle pulse.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      last_r   <= LAST_RST;
      result_r <= '0;
      src_r    <= '0;
      ack_r    <= '0;
      valid_r  <= 1'b0;
    end else begin
      ack_r <= '0;
      if (grant_s) begin
        result_r <= data_arr_s[g_s];
        src_r    <= g_s;
        ack_r    <= ONE_HOT0 << g_s;
        last_r   <= g_s;
        valid_r  <= 1'b1;
        cnt_r    <= CNT_RELOAD;
        state_r  <= ST_SHOW;
      end else if (dec_s) begin
        cnt_r <= cnt_r - CNT_W'(1);
      end else if (to_idle_s) begin
        state_r <= ST_IDLE;
      end else begin
        state_r <= state_r;
      end
    end
  end

  assign bus.Ack        = ack_r;
  assign bus.Result     = result_r;
  assign bus.Src_ID     = src_r;
  assign bus.Disp_Valid = valid_r;

endmodule

// File: tb/tb_display_arbiter.sv
// Directed bench for display_arbiter with NUM_SRC=4, HOLD_CYCLES=4.
module tb_display_arbiter;

  logic CLK;
  logic Reset;
  int   total;
  int   bad;

  display_arbiter_if #(.NUM_SRC(4), .DATA_W(16)) bus ();

  display_arbiter #(
    .NUM_SRC     (4),
    .DATA_W      (16),
    .HOLD_CYCLES (4)
  ) dut (
    .CLK   (CLK),
    .Reset (Reset),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic        rst;
    logic [3:0]  req;
    logic        hold;
    logic [3:0]  ack;
    logic [15:0] res;
    logic [1:0]  src;
    logic        vld;
  } vec_t;

  vec_t tv [19];

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [3:0] ea, input logic [15:0] er,
                     input logic [1:0] es, input logic ev);
    total++;
    if (bus.Ack !== ea) begin
      bad++;
      $display("FAIL %s Ack got=%b want=%b", nm, bus.Ack, ea);
    end
    total++;
    if (bus.Result !== er) begin
      bad++;
      $display("FAIL %s Result got=%h want=%h", nm, bus.Result, er);
    end
    total++;
    if (bus.Src_ID !== es) begin
      bad++;
      $display("FAIL %s Src_ID got=%0d want=%0d", nm, bus.Src_ID, es);
    end
    total++;
    if (bus.Disp_Valid !== ev) begin
      bad++;
      $display("FAIL %s Disp_Valid got=%b want=%b", nm, bus.Disp_Valid, ev);
    end
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    Reset     = 1'b1;
    bus.Req   = 4'b0000;
    bus.Hold  = 1'b0;
    bus.Data  = {16'hBEEF, 16'h00FF, 16'hABCD, 16'h1234};

    // Reset with all requests asserted, then continuous round robin.
    tv[0]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 16'h0000, 2'd0, 1'b0};
    tv[1]  = '{1'b1, 4'b1111, 1'b0, 4'b0000, 16'h0000, 2'd0, 1'b0};
    tv[2]  = '{1'b0, 4'b1111, 1'b0, 4'b0001, 16'h1234, 2'd0, 1'b1};
    tv[3]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'h1234, 2'd0, 1'b1};
    tv[4]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'h1234, 2'd0, 1'b1};
    tv[5]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'h1234, 2'd0, 1'b1};
    tv[6]  = '{1'b0, 4'b1111, 1'b0, 4'b0010, 16'hABCD, 2'd1, 1'b1};
    tv[7]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hABCD, 2'd1, 1'b1};
    tv[8]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hABCD, 2'd1, 1'b1};
    tv[9]  = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hABCD, 2'd1, 1'b1};
    tv[10] = '{1'b0, 4'b1111, 1'b0, 4'b0100, 16'h00FF, 2'd2, 1'b1};
    tv[11] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'h00FF, 2'd2, 1'b1};
    tv[12] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'h00FF, 2'd2, 1'b1};
    tv[13] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'h00FF, 2'd2, 1'b1};
    tv[14] = '{1'b0, 4'b1111, 1'b0, 4'b1000, 16'hBEEF, 2'd3, 1'b1};
    tv[15] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hBEEF, 2'd3, 1'b1};
    tv[16] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hBEEF, 2'd3, 1'b1};
    tv[17] = '{1'b0, 4'b1111, 1'b0, 4'b0000, 16'hBEEF, 2'd3, 1'b1};
    tv[18] = '{1'b0, 4'b1111, 1'b0, 4'b0001, 16'h1234, 2'd0, 1'b1};

    for (int i = 0; i < 19; i++) begin
      Reset    = tv[i].rst;
      bus.Req  = tv[i].req;
      bus.Hold = tv[i].hold;
      tick();
      chk($sformatf("vec%0d", i), tv[i].ack, tv[i].res, tv[i].src, tv[i].vld);
    end

    // Single request from source 2, dropped after Ack; display must persist.
    Reset = 1'b1; bus.Req = 4'b0000;
    tick();
    chk("a_reset", 4'b0000, 16'h0000, 2'd0, 1'b0);
    Reset = 1'b0; bus.Req = 4'b0100;
    tick();
    chk("a_grant", 4'b0100, 16'h00FF, 2'd2, 1'b1);
    bus.Req = 4'b0000;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk($sformatf("a_keep%0d", i), 4'b0000, 16'h00FF, 2'd2, 1'b1);
    end
    bus.Req = 4'b1001;
    tick();
    chk("a_rr_next", 4'b1000, 16'hBEEF, 2'd3, 1'b1);

    // Hold for 10 cycles mid-dwell stretches the display to 14 cycles.
    Reset = 1'b1; bus.Req = 4'b0000;
    tick();
    Reset = 1'b0; bus.Req = 4'b0011;
    tick();
    chk("b_grant0", 4'b0001, 16'h1234, 2'd0, 1'b1);
    tick();
    chk("b_dwell", 4'b0000, 16'h1234, 2'd0, 1'b1);
    bus.Hold = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk($sformatf("b_hold%0d", i), 4'b0000, 16'h1234, 2'd0, 1'b1);
    end
    bus.Hold = 1'b0;
    tick();
    chk("b_resume1", 4'b0000, 16'h1234, 2'd0, 1'b1);
    tick();
    chk("b_resume2", 4'b0000, 16'h1234, 2'd0, 1'b1);
    tick();
    chk("b_grant1", 4'b0010, 16'hABCD, 2'd1, 1'b1);

    // Data changing after the grant is ignored until the next grant.
    Reset = 1'b1; bus.Req = 4'b0000;
    tick();
    Reset = 1'b0; bus.Data[31:16] = 16'h0001; bus.Req = 4'b0010;
    tick();
    chk("c_grant", 4'b0010, 16'h0001, 2'd1, 1'b1);
    bus.Data[31:16] = 16'h0002;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("c_keep%0d", i), 4'b0000, 16'h0001, 2'd1, 1'b1);
    end
    tick();
    chk("c_regrant", 4'b0010, 16'h0002, 2'd1, 1'b1);

    // Reset two cycles into a dwell of source 3, then immediate regrant.
    Reset = 1'b1; bus.Req = 4'b0000;
    tick();
    Reset = 1'b0; bus.Req = 4'b1000;
    tick();
    chk("d_grant", 4'b1000, 16'hBEEF, 2'd3, 1'b1);
    tick();
    tick();
    chk("d_dwell", 4'b0000, 16'hBEEF, 2'd3, 1'b1);
    Reset = 1'b1;
    tick();
    chk("d_reset", 4'b0000, 16'h0000, 2'd0, 1'b0);
    Reset = 1'b0;
    tick();
    chk("d_after", 4'b1000, 16'hBEEF, 2'd3, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
